reducer3_2: RTL and testbench
=============================

// Module: reducer3_2
// PURPOSE
//  - Registered 3:2 carry-save reducer (CSA row). Compresses three WIDTH-bit operands into a
//    sum vector and a pre-shifted carry vector whose sum equals a+b+c.
//  - Feeds the multiplier/multi-operand adder tree of the datapath; no carry propagation inside.
// PARAMETERS
//  - WIDTH  32  operand width in bits
// PORTS
//  - clk    in   1         single clock; all state changes on rising edge
//  - rst_n  in   1         reset, synchronous, active-low
//  - start  in   1         operands valid; sampled on the rising edge of clk
//  - a      in   WIDTH     operand A
//  - b      in   WIDTH     operand B
//  - c      in   WIDTH     operand C
//  - res1   out  WIDTH+1   carry vector, already shifted left by one; res1[0] is always 0
//  - res2   out  WIDTH     sum vector
//  - done   out  1         res1/res2 valid for the operands of the previous start
//  - total  out  WIDTH+2   resolved sum; present only with REDUCER3_2_FINAL_ADD_EN
// BEHAVIOUR
//  - Per bit i: res2[i] = a[i]^b[i]^c[i].
//  - Per bit i: res1[i+1] = maj(a[i],b[i],c[i]); res1[0] = 0.
//  - Invariant: zero-extended res1 + res2 == a + b + c, exact in WIDTH+2 bits. No overflow is possible.
//  - Latency 1 cycle: a, b and c are captured on a clk edge when start=1.
//    On that edge res1 and res2 update, and done is 1 during the following cycle.
//  - done is 1 for exactly one cycle per accepted start.
//  - Back-to-back starts are accepted every cycle; done then stays 1 continuously.
//  - start=0: res1 and res2 hold their last values; done=0.
//  - Reset: while rst_n=0 at a clk edge, res1, res2 and done (and total) become 0.
//    Reset has priority over start. An in-flight result is discarded and done is not raised for it.
//  - First start after reset release is accepted normally.
//  - X-free: outputs are defined whenever rst_n has been applied.
// CONFIGURATION
//  - REDUCER3_2_FINAL_ADD_EN defined: adds output total = {1'b0,res1} + {2'b0,res2}.
//    total is combinational from the registered vectors and valid whenever done=1; latency is unchanged.
//  - Undefined: no total port and no carry-propagate adder. res1, res2 and done are unaffected.
// STRUCTURE
//  - Shared package reducer_pkg: RED_WIDTH = 32 default; derived widths CARRY_W = WIDTH+1 and TOTAL_W = WIDTH+2.
//  - One sub-module csa_cell (1-bit full-adder: x,y,z -> s,cy) instantiated WIDTH times via generate.
//  - Top holds the operand/result registers and the done flag.
// TESTING
//  - a=b=c=0xFFFFFFFF, start=1 -> next cycle:
//    res2=0xFFFFFFFF, res1=0x1_FFFFFFFE, done=1, total=0x2_FFFFFFFD.
//  - a=1, b=2, c=3 -> res2=0, res1=6, done=1 for one cycle only.
//  - a=5, b=0, c=0 -> res2=5, res1=0. Then start=0 for 3 cycles -> values held, done=0.
//  - 256 random triples back-to-back, start held 1:
//    each cycle res1+res2 == a+b+c of the previous cycle (64-bit compare), and done stays 1.
//  - Reset mid-op: start with a=b=c=7 and rst_n=0 on the same edge -> res1=res2=0, done=0.
//    No done pulse afterwards.
//  - Check res1[0]==0 on every done cycle. Without the macro, confirm the total port is absent.

Source files
------------

// File: rtl/reducer_pkg.sv
// Shared widths for the carry-save reducer family.
package reducer_pkg;

    localparam int unsigned RED_WIDTH = 32;
    localparam int unsigned CARRY_W   = RED_WIDTH + 1;
    localparam int unsigned TOTAL_W   = RED_WIDTH + 2;

    function automatic int unsigned carry_w(input int unsigned w);
        return w + 1;
    endfunction

    function automatic int unsigned total_w(input int unsigned w);
        return w + 2;
    endfunction

endpackage

// File: rtl/reducer3_2_csa_cell.sv
// One bit of a carry-save row: full adder producing sum and majority carry.
module csa_cell (
    input  logic x,
    input  logic y,
    input  logic z,
    output logic s,
    output logic cy
);

    assign s  = x ^ y ^ z;
    assign cy = (x & y) | (x & z) | (y & z);

endmodule

// File: rtl/reducer3_2.sv
// Registered 3:2 carry-save reducer: res1 (carry, pre-shifted) + res2 (sum) == a + b + c.
// Optional resolved sum output 'total' is enabled with REDUCER3_2_FINAL_ADD_EN.
module reducer3_2
    import reducer_pkg::*;
#(
    parameter int unsigned WIDTH = RED_WIDTH
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start,
    input  logic [WIDTH-1:0]              a,
    input  logic [WIDTH-1:0]              b,
    input  logic [WIDTH-1:0]              c,
    output logic [carry_w(WIDTH)-1:0]     res1,
    output logic [WIDTH-1:0]              res2,
    output logic                          done
`ifdef REDUCER3_2_FINAL_ADD_EN
    ,
    output logic [total_w(WIDTH)-1:0]     total
`endif
);

    logic [WIDTH-1:0]          sum_w;
    logic [WIDTH-1:0]          maj_w;

    logic [carry_w(WIDTH)-1:0] res1_d, res1_q;
    logic [WIDTH-1:0]          res2_d, res2_q;
    logic                      done_d, done_q;

    for (genvar i = 0; i < WIDTH; i++) begin : g_row
        csa_cell u_cell (
            .x  (a[i]),
            .y  (b[i]),
            .z  (c[i]),
            .s  (sum_w[i]),
            .cy (maj_w[i])
        );
    end

    always_comb begin
        res1_d = res1_q;
        res2_d = res2_q;
        done_d = 1'b0;
        if (start) begin
            res1_d = {maj_w, 1'b0};
            res2_d = sum_w;
            done_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            res1_q <= '0;
            res2_q <= '0;
            done_q <= 1'b0;
        end else begin
            res1_q <= res1_d;
            res2_q <= res2_d;
            done_q <= done_d;
        end
    end

    assign res1 = res1_q;
    assign res2 = res2_q;
    assign done = done_q;

`ifdef REDUCER3_2_FINAL_ADD_EN
    assign total = {1'b0, res1_q} + {2'b00, res2_q};
`endif

endmodule

// File: tb/tb_reducer3_2.sv
// Randomized self-checking bench for reducer3_2 against an arithmetic reference model.
module tb_reducer3_2;

    localparam int unsigned W = 32;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic [W-1:0]  a, b, c;
    logic [W:0]    res1;
    logic [W-1:0]  res2;
    logic          done;
`ifdef REDUCER3_2_FINAL_ADD_EN
    logic [W+1:0]  total;
`endif

    int unsigned checks = 0;
    int unsigned errors = 0;

    logic [63:0] exp_res1, exp_res2;
    logic        exp_done;

    reducer3_2 #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .c     (c),
        .res1  (res1),
        .res2  (res2),
        .done  (done)
`ifdef REDUCER3_2_FINAL_ADD_EN
        ,
        .total (total)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Drive one cycle, advance the model from the spec rules, then compare.
    task automatic step(input logic rst_v, input logic st, input logic [W-1:0] av,
                        input logic [W-1:0] bv, input logic [W-1:0] cv);
        logic [63:0] a64, b64, c64;
        rst_n = rst_v;
        start = st;
        a = av;
        b = bv;
        c = cv;
        a64 = {32'd0, av};
        b64 = {32'd0, bv};
        c64 = {32'd0, cv};
        @(posedge clk);
        #1;
        if (!rst_v) begin
            exp_res1 = '0;
            exp_res2 = '0;
            exp_done = 1'b0;
        end else if (st) begin
            exp_res2 = a64 ^ b64 ^ c64;
            exp_res1 = ((a64 & b64) | (a64 & c64) | (b64 & c64)) << 1;
            exp_done = 1'b1;
        end else begin
            exp_done = 1'b0;
        end
        check("res1", {31'd0, res1}, exp_res1);
        check("res2", {32'd0, res2}, exp_res2);
        check("done", {63'd0, done}, {63'd0, exp_done});
        if (exp_done) begin
            check("res1_lsb", {63'd0, res1[0]}, 64'd0);
            check("csa_sum", {31'd0, res1} + {32'd0, res2}, a64 + b64 + c64);
        end
`ifdef REDUCER3_2_FINAL_ADD_EN
        check("total", {30'd0, total}, exp_res1 + exp_res2);
`endif
    endtask

    initial begin
        exp_res1 = '0;
        exp_res2 = '0;
        exp_done = 1'b0;
        rst_n = 1'b0;
        start = 1'b0;
        a = '0;
        b = '0;
        c = '0;

        step(1'b0, 1'b0, '0, '0, '0);
        step(1'b0, 1'b1, 32'h1234_5678, 32'h9ABC_DEF0, 32'h0F0F_0F0F);

        step(1'b1, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        check("ones_res2", {32'd0, res2}, 64'hFFFF_FFFF);
        check("ones_res1", {31'd0, res1}, 64'h1_FFFF_FFFE);
`ifdef REDUCER3_2_FINAL_ADD_EN
        check("ones_total", {30'd0, total}, 64'h2_FFFF_FFFD);
`endif

        step(1'b1, 1'b1, 32'd1, 32'd2, 32'd3);
        check("small_res2", {32'd0, res2}, 64'd0);
        check("small_res1", {31'd0, res1}, 64'd6);
        step(1'b1, 1'b0, '0, '0, '0);

        step(1'b1, 1'b1, 32'd5, 32'd0, 32'd0);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b0, $urandom, $urandom, $urandom);
            check("hold_res2", {32'd0, res2}, 64'd5);
        end

        for (int i = 0; i < 256; i++)
            step(1'b1, 1'b1, $urandom, $urandom, $urandom);

        step(1'b1, 1'b1, 32'hDEAD_BEEF, 32'h0BAD_F00D, 32'hCAFE_0001);
        step(1'b0, 1'b1, 32'd7, 32'd7, 32'd7);
        for (int i = 0; i < 3; i++)
            step(1'b1, 1'b0, $urandom, $urandom, $urandom);

        step(1'b1, 1'b1, 32'd7, 32'd7, 32'd7);
        check("post_rst_res1", {31'd0, res1}, 64'd14);
        step(1'b1, 1'b0, '0, '0, '0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
